// File: rtl/alu_share_arbiter.sv
// Arbitrates the shared combinational ALU between the execute issue port (r0)
// and the auxiliary address/CSR port (r1), returning results through a one-entry buffer.
module alu_share_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned WAIT_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [3:0]  r0_code,
    input  logic [31:0] r0_srcA,
    input  logic [31:0] r0_srcB,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [3:0]  r1_code,
    input  logic [31:0] r1_srcA,
    input  logic [31:0] r1_srcB,

    output logic [3:0]  alu_code,
    output logic [31:0] alu_srcA,
    output logic [31:0] alu_srcB,
    input  logic [31:0] alu_result,
    input  logic        alu_branch,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_branch,
    output logic        resp_id
);

    // state     | meaning
    // BUF_EMPTY | no response held; any winner may be accepted
    // BUF_FULL  | response held; a new accept needs resp_ready in the same cycle
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    localparam logic [3:0] WAIT_MAX = 4'(WAIT_LIMIT);

    buf_state_t  state;
    buf_state_t  state_next;
    logic        last_grant;
    logic [3:0]  wait_cnt;
    logic        win;
    logic        any_valid;
    logic        accept_en;
    logic        accept;
    logic [31:0] result_q;
    logic        branch_q;
    logic        id_q;

    assign resp_valid  = (state == BUF_FULL);
    assign resp_result = result_q;
    assign resp_branch = branch_q;
    assign resp_id     = id_q;

    assign accept_en = !resp_valid || resp_ready;
    assign any_valid = r0_valid || r1_valid;

    // win selects the requester that owns the ALU this cycle (0 or 1)
    always_comb begin
        win = 1'b0;
        if (r0_valid && r1_valid) begin
            if (FIXED_PRIO)
                win = (wait_cnt == WAIT_MAX);
            else
                win = ~last_grant;
        end else if (r1_valid) begin
            win = 1'b1;
        end
    end

    // Operands follow the winner even while stalled so the ALU output stays stable.
    always_comb begin
        alu_code = 4'b0000;
        alu_srcA = 32'h0;
        alu_srcB = 32'h0;
        if (any_valid) begin
            if (win) begin
                alu_code = r1_code;
                alu_srcA = r1_srcA;
                alu_srcB = r1_srcB;
            end else begin
                alu_code = r0_code;
                alu_srcA = r0_srcA;
                alu_srcB = r0_srcB;
            end
        end
    end

    assign r0_ready = accept_en && r0_valid && !win;
    assign r1_ready = accept_en && r1_valid && win;
    assign accept   = r0_ready || r1_ready;

    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (accept) state_next = BUF_FULL;
            BUF_FULL:  if (resp_ready && !accept) state_next = BUF_EMPTY;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= BUF_EMPTY;
        else
            state <= state_next;
    end

    // A drain and a new accept on the same edge simply overwrite the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 32'h0;
            branch_q <= 1'b0;
            id_q     <= 1'b0;
        end else if (accept) begin
            result_q <= alu_result;
            branch_q <= alu_branch;
            id_q     <= win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!FIXED_PRIO) begin
            wait_cnt <= 4'd0;
        end else if (!r1_valid || r1_ready) begin
            wait_cnt <= 4'd0;
        end else if (accept_en && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority (WAIT_LIMIT=3)
// instance share requester stimulus; each has its own small ALU model.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r1_valid;
    logic [3:0]  r0_code, r1_code;
    logic [31:0] r0_srcA, r0_srcB, r1_srcA, r1_srcB;
    logic        resp_ready;

    logic        rr_r0_ready, rr_r1_ready;
    logic [3:0]  rr_alu_code;
    logic [31:0] rr_alu_srcA, rr_alu_srcB, rr_alu_result;
    logic        rr_alu_branch;
    logic        rr_resp_valid, rr_resp_branch, rr_resp_id;
    logic [31:0] rr_resp_result;

    logic        fp_r0_ready, fp_r1_ready;
    logic [3:0]  fp_alu_code;
    logic [31:0] fp_alu_srcA, fp_alu_srcB, fp_alu_result;
    logic        fp_alu_branch;
    logic        fp_resp_valid, fp_resp_branch, fp_resp_id;
    logic [31:0] fp_resp_result;

    int checks = 0;
    int errors = 0;

    // 0000 add, 0001 sub, 1010 beq (result 0), others xor
    function automatic logic [32:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: alu_f = {1'b0, a + b};
            4'b0001: alu_f = {1'b0, a - b};
            4'b1010: alu_f = {(a == b), 32'h0};
            default: alu_f = {1'b0, a ^ b};
        endcase
    endfunction

    assign {rr_alu_branch, rr_alu_result} = alu_f(rr_alu_code, rr_alu_srcA, rr_alu_srcB);
    assign {fp_alu_branch, fp_alu_result} = alu_f(fp_alu_code, fp_alu_srcA, fp_alu_srcB);

    alu_share_arbiter #(.FIXED_PRIO(1'b0), .WAIT_LIMIT(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(rr_r0_ready), .r0_code(r0_code), .r0_srcA(r0_srcA), .r0_srcB(r0_srcB),
        .r1_valid(r1_valid), .r1_ready(rr_r1_ready), .r1_code(r1_code), .r1_srcA(r1_srcA), .r1_srcB(r1_srcB),
        .alu_code(rr_alu_code), .alu_srcA(rr_alu_srcA), .alu_srcB(rr_alu_srcB),
        .alu_result(rr_alu_result), .alu_branch(rr_alu_branch),
        .resp_valid(rr_resp_valid), .resp_ready(resp_ready), .resp_result(rr_resp_result),
        .resp_branch(rr_resp_branch), .resp_id(rr_resp_id)
    );

    alu_share_arbiter #(.FIXED_PRIO(1'b1), .WAIT_LIMIT(3)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_code(r0_code), .r0_srcA(r0_srcA), .r0_srcB(r0_srcB),
        .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_code(r1_code), .r1_srcA(r1_srcA), .r1_srcB(r1_srcB),
        .alu_code(fp_alu_code), .alu_srcA(fp_alu_srcA), .alu_srcB(fp_alu_srcB),
        .alu_result(fp_alu_result), .alu_branch(fp_alu_branch),
        .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_result(fp_resp_result),
        .resp_branch(fp_resp_branch), .resp_id(fp_resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        r0_valid = 1'b0; r0_code = 4'h0; r0_srcA = 32'h0; r0_srcB = 32'h0;
        r1_valid = 1'b0; r1_code = 4'h0; r1_srcA = 32'h0; r1_srcB = 32'h0;
        resp_ready = 1'b0;
        #2;
        chk("rst_resp_valid", 32'(rr_resp_valid), 32'd0);
        chk("rst_resp_result", rr_resp_result, 32'h0);
        chk("rst_resp_id", 32'(rr_resp_id), 32'd0);
        chk("idle_alu_code", 32'(rr_alu_code), 32'd0);
        chk("idle_alu_srcA", rr_alu_srcA, 32'h0);
        #10 rst_n = 1'b1;
        tick();

        // r0 alone: add 5 + 3
        r0_valid = 1'b1; r0_code = 4'b0000; r0_srcA = 32'd5; r0_srcB = 32'd3;
        resp_ready = 1'b1;
        #1;
        chk("r0only_ready", 32'(rr_r0_ready), 32'd1);
        chk("r0only_r1_ready", 32'(rr_r1_ready), 32'd0);
        chk("r0only_alu_srcA", rr_alu_srcA, 32'd5);
        tick();
        r0_valid = 1'b0;
        chk("r0only_resp_valid", 32'(rr_resp_valid), 32'd1);
        chk("r0only_result", rr_resp_result, 32'd8);
        chk("r0only_branch", 32'(rr_resp_branch), 32'd0);
        chk("r0only_id", 32'(rr_resp_id), 32'd0);

        // r1 alone: beq with equal operands
        r1_valid = 1'b1; r1_code = 4'b1010; r1_srcA = 32'h1234; r1_srcB = 32'h1234;
        #1;
        chk("r1only_ready", 32'(rr_r1_ready), 32'd1);
        chk("r1only_r0_ready", 32'(rr_r0_ready), 32'd0);
        tick();
        r1_valid = 1'b0;
        chk("r1only_result", rr_resp_result, 32'h0);
        chk("r1only_branch", 32'(rr_resp_branch), 32'd1);
        chk("r1only_id", 32'(rr_resp_id), 32'd1);

        // round-robin: r0 = 1+1 = 2, r1 = 10-4 = 6; last grant was r1 so r0 goes first
        r0_valid = 1'b1; r0_code = 4'b0000; r0_srcA = 32'd1;  r0_srcB = 32'd1;
        r1_valid = 1'b1; r1_code = 4'b0001; r1_srcA = 32'd10; r1_srcB = 32'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_r0_ready", 32'(rr_r0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_r1_ready", 32'(rr_r1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr_resp_valid", 32'(rr_resp_valid), 32'd1);
            chk("rr_resp_id", 32'(rr_resp_id), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_resp_result", rr_resp_result, (i % 2 == 1) ? 32'd6 : 32'd2);
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
        chk("drain_resp_valid", 32'(rr_resp_valid), 32'd0);

        // backpressure: 100 + 23 fills the buffer, then 7 + 8 waits
        resp_ready = 1'b0;
        r0_valid = 1'b1; r0_code = 4'b0000; r0_srcA = 32'd100; r0_srcB = 32'd23;
        #1;
        chk("bp_first_ready", 32'(rr_r0_ready), 32'd1);
        tick();
        r0_srcA = 32'd7; r0_srcB = 32'd8;
        #1;
        chk("bp_stall_ready", 32'(rr_r0_ready), 32'd0);
        chk("bp_stall_alu_srcA", rr_alu_srcA, 32'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_ready", 32'(rr_r0_ready), 32'd0);
            chk("bp_hold_valid", 32'(rr_resp_valid), 32'd1);
            chk("bp_hold_result", rr_resp_result, 32'd123);
            chk("bp_hold_alu_srcB", rr_alu_srcB, 32'd8);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rr_r0_ready), 32'd1);
        tick();
        r0_valid = 1'b0;
        chk("bp_new_valid", 32'(rr_resp_valid), 32'd1);
        chk("bp_new_result", rr_resp_result, 32'd15);
        chk("bp_new_id", 32'(rr_resp_id), 32'd0);
        tick();
        chk("bp_drained", 32'(rr_resp_valid), 32'd0);

        // fixed priority with WAIT_LIMIT=3: grants 0,0,0,1,0,0,0,1
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fp_r0_ready", 32'(fp_r0_ready), (i % 4 == 3) ? 32'd0 : 32'd1);
            chk("fp_r1_ready", 32'(fp_r1_ready), (i % 4 == 3) ? 32'd1 : 32'd0);
            tick();
            chk("fp_resp_id", 32'(fp_resp_id), (i % 4 == 3) ? 32'd1 : 32'd0);
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();

        // asynchronous reset while a response is stuck in the buffer
        resp_ready = 1'b0;
        r1_valid = 1'b1; r1_code = 4'b0000; r1_srcA = 32'd40; r1_srcB = 32'd2;
        tick();
        r1_valid = 1'b0;
        chk("pre_rst_valid", 32'(rr_resp_valid), 32'd1);
        chk("pre_rst_result", rr_resp_result, 32'd42);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rr_resp_valid), 32'd0);
        chk("async_rst_result", rr_resp_result, 32'h0);
        chk("async_rst_fp_valid", 32'(fp_resp_valid), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        resp_ready = 1'b1;
        r0_valid = 1'b1; r0_code = 4'b0000; r0_srcA = 32'd9; r0_srcB = 32'd9;
        r1_valid = 1'b1; r1_code = 4'b0000; r1_srcA = 32'd1; r1_srcB = 32'd2;
        #1;
        chk("post_rst_r0_ready", 32'(rr_r0_ready), 32'd1);
        chk("post_rst_r1_ready", 32'(rr_r1_ready), 32'd0);
        chk("post_rst_alu_srcA", rr_alu_srcA, 32'd9);
        tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        chk("post_rst_id", 32'(rr_resp_id), 32'd0);
        chk("post_rst_result", rr_resp_result, 32'd18);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
